// File: rtl/fft_butterfly_sequencer.sv
// Butterfly sequencer for an in-place radix-2 DIT FFT: walks every stage
// and butterfly, emitting data-RAM address pairs and twiddle ROM indices.
module fft_butterfly_sequencer #(
    parameter int ADDR_WIDTH  = 4,
    parameter int STAGE_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stall,
    input  logic                   abort,
    output logic                   busy,
    output logic                   valid,
    output logic                   last,
    output logic                   done,
    output logic [STAGE_WIDTH-1:0] stage,
    output logic [ADDR_WIDTH-1:0]  addr_a,
    output logic [ADDR_WIDTH-1:0]  addr_b,
    output logic [ADDR_WIDTH-1:0]  tw_addr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int KW = ADDR_WIDTH - 1;
    localparam logic [KW-1:0] K_MAX = '1;
    localparam logic [STAGE_WIDTH-1:0] S_MAX = STAGE_WIDTH'(ADDR_WIDTH - 1);

    logic [1:0]             state_q, state_d;
    logic [STAGE_WIDTH-1:0] s_q, s_d;
    logic [KW-1:0]          k_q, k_d;
    logic                   k_end, s_end;

    assign valid = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign busy  = (state_q != S_IDLE);
    assign k_end = (k_q == K_MAX);
    assign s_end = (s_q == S_MAX);
    assign last  = valid & k_end & s_end;
    assign stage = s_q;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    s_d     = '0;
                    k_d     = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    s_d     = '0;
                    k_d     = '0;
                end else if (!stall) begin
                    if (last) begin
                        state_d = S_DONE;
                        s_d     = '0;
                        k_d     = '0;
                    end else if (k_end) begin
                        k_d = '0;
                        s_d = s_q + 1'b1;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                s_d     = '0;
                k_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
                s_d     = '0;
                k_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            s_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
        end
    end

    logic [ADDR_WIDTH-1:0]  kx, half, j, g, base;
    logic [STAGE_WIDTH-1:0] tw_sh;

    // k splits into group g (high bits) and in-group offset j (low s bits)
    always_comb begin
        kx    = {1'b0, k_q};
        half  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << s_q;
        j     = kx & (half - 1'b1);
        g     = kx >> s_q;
        base  = (g << s_q) << 1;
        tw_sh = S_MAX - s_q;
        addr_a  = '0;
        addr_b  = '0;
        tw_addr = '0;
        if (valid) begin
            addr_a  = base | j;
            addr_b  = (base | j) + half;
            tw_addr = j << tw_sh;
        end
    end

endmodule

// File: tb/tb_fft_butterfly_sequencer.sv
// Directed bench for fft_butterfly_sequencer: full 16-point sequences,
// spot vectors, stall, restart, abort and asynchronous reset.
module tb_fft_butterfly_sequencer;

    localparam int AW = 4;
    localparam int SW = 2;
    localparam int NB = 32;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic          abort = 1'b0;
    logic          busy, valid, last, done;
    logic [SW-1:0] stage;
    logic [AW-1:0] addr_a, addr_b, tw_addr;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int beat;
        int a;
        int b;
        int tw;
        int lst;
    } vec_t;

    vec_t vecs[10];
    int   ea[NB];
    int   eb[NB];
    int   et[NB];
    int   es[NB];

    always #5 clk = ~clk;

    fft_butterfly_sequencer #(
        .ADDR_WIDTH (AW),
        .STAGE_WIDTH(SW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stall  (stall),
        .abort  (abort),
        .busy   (busy),
        .valid  (valid),
        .last   (last),
        .done   (done),
        .stage  (stage),
        .addr_a (addr_a),
        .addr_b (addr_b),
        .tw_addr(tw_addr)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack_out();
        return {14'd0, busy, valid, done, stage,
                addr_a, addr_b, tw_addr, last};
    endfunction

    function automatic logic [31:0] pack_exp(input int i);
        int l;
        l = (i == NB - 1) ? 1 : 0;
        return 32'((1 << 17) | (1 << 16) | (es[i] << 13) | (ea[i] << 9)
                   | (eb[i] << 5) | (et[i] << 1) | l);
    endfunction

    task automatic run_seq(input string tag, input int stall_at,
                           input int stall_n, input int repulse_at,
                           input int abort_at, input int rst_at,
                           output int nvalid, output int done_cyc,
                           output bit cut);
        int cyc, beat, held;
        nvalid   = 0;
        done_cyc = -1;
        cut      = 1'b0;
        beat     = 0;
        held     = 0;
        @(posedge clk);
        #1;
        check({tag, " idle before start"}, {busy, valid, done, last}, 0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({tag, " first valid"}, valid, 1);
            if (valid) begin
                nvalid++;
                if (beat < NB) begin
                    check({tag, $sformatf(" beat%0d", beat)},
                          pack_out(), pack_exp(beat));
                    for (int i = 0; i < 10; i++) begin
                        if (vecs[i].beat == beat)
                            check({tag, $sformatf(" vec%0d", i)},
                                  {addr_a, addr_b, tw_addr, last},
                                  32'((vecs[i].a << 9) | (vecs[i].b << 5)
                                      | (vecs[i].tw << 1) | vecs[i].lst));
                    end
                end else begin
                    check({tag, " beat overflow"}, beat, NB - 1);
                end
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check({tag, " async reset outputs"}, pack_out(), 0);
                cut = 1'b1;
                break;
            end
            if (valid && beat == abort_at) begin
                abort = 1'b1;
                @(posedge clk);
                #1 abort = 1'b0;
                cut = 1'b1;
                break;
            end
            stall = valid && beat == stall_at && held < stall_n;
            if (stall) held++;
            start = (cyc == repulse_at);
            if (valid && !stall) beat++;
        end
        stall = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int  nv, dc, seen;
        bit  cut;
        int  idx;

        vecs[0] = '{0, 0, 1, 0, 0};
        vecs[1] = '{1, 2, 3, 0, 0};
        vecs[2] = '{7, 14, 15, 0, 0};
        vecs[3] = '{9, 1, 3, 4, 0};
        vecs[4] = '{12, 8, 10, 0, 0};
        vecs[5] = '{19, 3, 7, 6, 0};
        vecs[6] = '{20, 8, 12, 0, 0};
        vecs[7] = '{21, 9, 13, 2, 0};
        vecs[8] = '{24, 0, 8, 0, 0};
        vecs[9] = '{31, 7, 15, 7, 1};

        idx = 0;
        for (int s = 0; s < AW; s++) begin
            int half;
            half = 1 << s;
            for (int g = 0; g < 8 / half; g++) begin
                for (int j = 0; j < half; j++) begin
                    ea[idx] = g * 2 * half + j;
                    eb[idx] = ea[idx] + half;
                    et[idx] = j * (8 / half);
                    es[idx] = s;
                    idx++;
                end
            end
        end

        #2 rst_n = 1'b0;
        #2;
        check("reset state", pack_out(), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_seq("plain", -1, 0, -1, -1, -1, nv, dc, cut);
        check("plain valid count", nv, 32);
        check("plain done cycle", dc, 33);

        run_seq("stall", 19, 3, -1, -1, -1, nv, dc, cut);
        check("stall valid count", nv, 35);
        check("stall done cycle", dc, 36);

        run_seq("repulse", -1, 0, 5, -1, -1, nv, dc, cut);
        check("repulse valid count", nv, 32);
        check("repulse done cycle", dc, 33);

        run_seq("back2back", -1, 0, -1, -1, -1, nv, dc, cut);
        check("back2back valid count", nv, 32);
        check("back2back done cycle", dc, 33);

        run_seq("abort", -1, 0, -1, 12, -1, nv, dc, cut);
        check("abort taken", cut, 1);
        check("abort valid count", nv, 13);
        @(negedge clk);
        check("abort idle outputs", pack_out(), 0);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("abort no done", seen, 0);

        run_seq("after abort", -1, 0, -1, -1, -1, nv, dc, cut);
        check("after abort valid count", nv, 32);
        check("after abort done cycle", dc, 33);

        run_seq("reset", -1, 0, -1, -1, 10, nv, dc, cut);
        check("reset taken", cut, 1);
        check("reset valid count", nv, 10);
        @(negedge clk);
        check("reset held outputs", pack_out(), 0);
        rst_n = 1'b1;

        run_seq("after reset", -1, 0, -1, -1, -1, nv, dc, cut);
        check("after reset valid count", nv, 32);
        check("after reset done cycle", dc, 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fft_butterfly_sequencer.md
Name: fft_butterfly_sequencer

Overview:
Control sequencer for the in-place radix-2 decimation-in-time (DIT) N-point FFT datapath, where N = 2**ADDR_WIDTH.
- After a start pulse it steps through all ADDR_WIDTH stages × N/2 butterflies, one per accepted cycle.
- Each step drives the data-memory address pair (addr_a, addr_b) and the twiddle ROM address for that butterfly.
- Sits between the top-level FFT control and the data RAM / twiddle ROM / butterfly unit.
- Memory must already hold input in bit-reversed order (loaded via the bit-reversal path).

Parameters:
ADDR_WIDTH, 4, log2(N); N = 2**ADDR_WIDTH points.
STAGE_WIDTH, 2, width of stage index; must satisfy 2**STAGE_WIDTH >= ADDR_WIDTH.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a transform; sampled only in IDLE
stall  input  1  downstream not ready; holds current butterfly
abort  input  1  synchronous cancel; returns to IDLE next cycle
busy  output  1  high in RUN and DONE
valid  output  1  current addr_a/addr_b/tw_addr describe a butterfly
last  output  1  current butterfly is final of final stage (qualified by valid)
done  output  1  one-cycle pulse after final butterfly accepted
stage  output  STAGE_WIDTH  current stage s, 0..ADDR_WIDTH-1
addr_a  output  ADDR_WIDTH  upper-leg data address
addr_b  output  ADDR_WIDTH  lower-leg data address
tw_addr  output  ADDR_WIDTH  twiddle ROM index (W_N^tw_addr)

Behaviour:
- Reset (rst_n low, async): state=IDLE. busy, valid, last, done=0. stage, addr_a, addr_b, tw_addr, internal butterfly counter k=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge -> RUN; s=0, k=0.
  - First butterfly is presented with valid=1 in the next cycle (1-cycle latency start->valid).
- RUN:
  - valid=1 throughout.
  - A butterfly is accepted on a rising edge when stall=0.
  - On accept: if k < N/2-1, k increments. Otherwise k=0 and s increments.
  - Accept while last=1 -> DONE.
  - stall=1: all outputs held unchanged; no advance.
- DONE: valid=0, done=1 for exactly one cycle, then IDLE. busy stays high in DONE.
- abort=1 in RUN or DONE -> IDLE next edge; valid/done=0, counters cleared. abort has priority over stall and accept. abort in IDLE has no effect.
- start while busy: ignored. start and abort together in IDLE: start wins, since abort has no effect in IDLE.
- Address generation, combinational from registered s, k (k is ADDR_WIDTH-1 bits):
  - half = 1<<s
  - j = k & (half-1)
  - g = k >> s
  - addr_a = (g << (s+1)) | j
  - addr_b = addr_a + half
  - tw_addr = j << (ADDR_WIDTH-1-s)
  - All results truncated to ADDR_WIDTH; no overflow occurs for legal s.
- last = valid & (s==ADDR_WIDTH-1) & (k==N/2-1).
- Total accepted butterflies per transform = ADDR_WIDTH*N/2. With no stall: busy for ADDR_WIDTH*N/2+1 cycles; done appears ADDR_WIDTH*N/2+1 cycles after the start edge.
- Outputs are registered state decoded combinationally; no glitch requirement beyond standard synchronous use.
- Reset asserted mid-transform: immediate return to reset values. No resume.

Test Plan:
1. Reset, then start pulse with stall=0, N=16 -> valid rises 1 cycle after start. Expected sequence:
   - first beat (s0,k0): a=0, b=1, tw=0
   - (s0,k1): a=2, b=3, tw=0
   - 32 valid cycles total; done high exactly on cycle 33, then IDLE.
2. Spot-check addresses in the same run:
   - s1,k1: a=1, b=3, tw=4
   - s2,k5: a=9, b=13, tw=2
   - s3,k7: a=7, b=15, tw=7, with last=1
3. stall=1 for 3 cycles at s2,k3 -> outputs frozen (a=3, b=7, tw=6); sequence resumes at s2,k4 (a=8, b=12, tw=0); done delayed by 3 cycles.
4. start re-pulsed during RUN -> ignored; sequence and done timing identical to scenario 1. start in the cycle after done -> new transform begins normally.
5. abort at s1,k4 -> next cycle valid=0, busy=0, no done pulse. A following start restarts at s0,k0.
6. rst_n driven low asynchronously mid-RUN (between clock edges) -> outputs zero immediately. After release and start, full 32-butterfly sequence repeats.
